// File: rtl/dump_pkg.sv
// Shared types for the memory-dump transmitter: state encoding, byte type, header size.
package dump_pkg;

  localparam int HDR_BYTES = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_RDW,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO,
    S_SUM,
    S_DONE
  } dump_state_t;

endpackage

// File: rtl/dump_byte_sender.sv
// One-byte-in-flight handshake with uart_tx: pulse send, wait for sending to rise, then fall.
// Handshake: i_load is honoured only while o_idle; o_uart_send is a one-enabled-cycle pulse.
module dump_byte_sender
  import dump_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clk_enable,
  input  logic        i_load,
  input  byte_t       i_byte_in,
  input  logic        i_uart_sending,
  output byte_t       o_uart_data,
  output logic        o_uart_send,
  output logic        o_idle,
  output dump_state_t o_state
);

  dump_state_t r_state;
  byte_t       r_data;
  logic        r_send;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_send  <= 1'b0;
    end else if (i_clk_enable) begin
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_data  <= i_byte_in;
            r_send  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          r_send  <= 1'b0;
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: if (i_uart_sending) r_state <= S_WAIT_LO;
        S_WAIT_LO: if (!i_uart_sending) r_state <= S_IDLE;
        default: begin
          r_send  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_uart_data = r_data;
  assign o_uart_send = r_send;
  assign o_idle      = (r_state == S_IDLE);
  assign o_state     = r_state;

endmodule

// File: rtl/mem_dump_tx.sv
// Streams a memory range over UART: 4-byte little-endian length header, then the payload bytes.
// Define DUMP_CHECKSUM_EN to append an 8-bit modular sum of the payload as a trailing byte.
module mem_dump_tx
  import dump_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clk_enable,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_re,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [7:0]            i_mem_data,
  output logic [7:0]            o_uart_data,
  output logic                  o_uart_send,
  input  logic                  i_uart_sending,
  output dump_state_t           o_state
);

  dump_state_t           r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_mem_re;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [31:0]           r_len_hdr;
  logic [1:0]            r_hdr_idx;
`ifdef DUMP_CHECKSUM_EN
  byte_t                 r_sum;
  logic                  r_sum_sent;
`endif

  logic [31:0]  w_len32;
  logic         w_load;
  byte_t        w_byte;
  logic         w_snd_idle;
  logic         w_byte_done;
  dump_state_t  w_snd_state;

  generate
    if (LEN_WIDTH >= 32) begin : g_len_trunc
      assign w_len32 = i_length[31:0];
    end else begin : g_len_ext
      assign w_len32 = {{(32-LEN_WIDTH){1'b0}}, i_length};
    end
  endgenerate

  // Byte handed to the sender: header slice, fresh memory data, or the checksum.
  always_comb begin
    w_byte = '0;
    w_load = 1'b0;
    case (r_state)
      S_HDR: begin
        w_byte = 8'(r_len_hdr >> {r_hdr_idx, 3'b000});
        w_load = w_snd_idle;
      end
      S_RDW: begin
        w_byte = i_mem_data;
        w_load = w_snd_idle;
      end
`ifdef DUMP_CHECKSUM_EN
      S_SUM: begin
        w_byte = r_sum;
        w_load = w_snd_idle;
      end
`endif
      default: ;
    endcase
  end

  assign w_byte_done = (r_state == S_SEND) && (w_snd_state == S_WAIT_LO) && !i_uart_sending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_len_hdr   <= '0;
      r_hdr_idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
      r_sum       <= '0;
      r_sum_sent  <= 1'b0;
`endif
    end else if (i_clk_enable) begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cur_addr  <= i_base_addr;
            r_remaining <= i_length;
            r_len_hdr   <= w_len32;
            r_hdr_idx   <= '0;
            r_busy      <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            r_sum       <= '0;
            r_sum_sent  <= 1'b0;
`endif
            r_state     <= S_HDR;
          end
        end
        S_HDR: r_state <= S_SEND;
        S_RD: begin
          r_mem_re <= 1'b0;
          r_state  <= S_RDW;
        end
        S_RDW: begin
          r_cur_addr  <= r_cur_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
`ifdef DUMP_CHECKSUM_EN
          r_sum       <= r_sum + i_mem_data;
`endif
          r_state     <= S_SEND;
        end
        // Top parks in S_SEND while the sender walks SEND/WAIT_HI/WAIT_LO.
        S_SEND: begin
          if (w_byte_done) begin
            if (r_hdr_idx != 2'(HDR_BYTES - 1)) begin
              r_hdr_idx <= r_hdr_idx + 1'b1;
              r_state   <= S_HDR;
            end else if (r_remaining != '0) begin
              r_mem_re   <= 1'b1;
              r_mem_addr <= r_cur_addr;
              r_state    <= S_RD;
`ifdef DUMP_CHECKSUM_EN
            end else if (!r_sum_sent) begin
              r_state <= S_SUM;
`endif
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_SUM: begin
          r_sum_sent <= 1'b1;
          r_state    <= S_SEND;
        end
`endif
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  dump_byte_sender u_sender (
    .clk            (clk),
    .reset          (reset),
    .i_clk_enable   (i_clk_enable),
    .i_load         (w_load),
    .i_byte_in      (w_byte),
    .i_uart_sending (i_uart_sending),
    .o_uart_data    (o_uart_data),
    .o_uart_send    (o_uart_send),
    .o_idle         (w_snd_idle),
    .o_state        (w_snd_state)
  );

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_mem_re   = r_mem_re;
  assign o_mem_addr = r_mem_addr;
  assign o_state    = (r_state == S_SEND) ? w_snd_state : r_state;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: memory and uart_tx peers, expected-byte queue, per-scenario tasks.
module tb_mem_dump_tx;
  import dump_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] length;
  logic        busy, done, mem_re, uart_send;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  uart_data;
  logic        uart_sending;
  dump_state_t state;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int sent_cnt = 0;
  int uart_cnt = 0;
  logic en_toggle = 1'b0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] addr_q[$];
  logic [7:0]  tb_mem [logic [31:0]];

  always #5 clk = ~clk;

  mem_dump_tx #(.ADDR_WIDTH(32), .LEN_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_clk_enable   (clk_enable),
    .i_start        (start),
    .i_base_addr    (base_addr),
    .i_length       (length),
    .o_busy         (busy),
    .o_done         (done),
    .o_mem_re       (mem_re),
    .o_mem_addr     (mem_addr),
    .i_mem_data     (mem_data),
    .o_uart_data    (uart_data),
    .o_uart_send    (uart_send),
    .i_uart_sending (uart_sending),
    .o_state        (state)
  );

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (tb_mem.exists(a)) return tb_mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // Byte-wide memory: data returned on the enabled edge that samples mem_re.
  always @(posedge clk) begin
    if (!reset && clk_enable && mem_re) begin
      mem_data <= mem_rd(mem_addr);
      addr_q.push_back(mem_addr);
    end
  end

  // uart_tx peer: sending rises the edge after send and stays high a random bit time.
  always @(posedge clk) begin
    if (reset) begin
      uart_sending <= 1'b0;
      uart_cnt     <= 0;
    end else if (clk_enable) begin
      if (uart_send && !uart_sending) begin
        uart_sending <= 1'b1;
        uart_cnt     <= $urandom_range(1, 5);
        got_q.push_back(uart_data);
        sent_cnt     <= sent_cnt + 1;
      end else if (uart_sending) begin
        if (uart_cnt == 0) uart_sending <= 1'b0;
        else uart_cnt <= uart_cnt - 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (en_toggle) clk_enable = ~clk_enable;
    else clk_enable = 1'b1;
    while (got_q.size() > 0) begin
      logic [7:0] b;
      logic [7:0] e;
      b = got_q.pop_front();
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL uart_byte: got %02h, expected no byte", b);
      end else begin
        e = exp_q.pop_front();
        if (b !== e) begin
          n_err++;
          $display("FAIL uart_byte: got %02h, expected %02h", b, e);
        end
      end
    end
    if (uart_send === 1'b1) begin
      n_vec++;
      if (uart_sending !== 1'b0) begin
        n_err++;
        $display("FAIL send_while_sending: uart_sending=%b, expected 0", uart_sending);
      end
    end
  end

  task automatic push_frame(input logic [31:0] b, input logic [31:0] len);
    logic [7:0] s;
    logic [7:0] d;
    s = '0;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(len >> (8 * i)));
    for (int i = 0; i < int'(len); i++) begin
      d = mem_rd(b + 32'(i));
      exp_q.push_back(d);
      s = s + d;
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  task automatic drive_start(input logic [31:0] b, input logic [31:0] len);
    @(negedge clk);
    base_addr = b;
    length    = len;
    start     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      if (clk_enable) break;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] b, input logic [31:0] len, input bit chk_lat,
                           input bit busy_start);
    int  d0;
    bit  ok;
    addr_q.delete();
    push_frame(b, len);
    d0 = done_cnt;
    drive_start(b, len);
    if (chk_lat) begin
      n_vec++;
      if (state !== S_HDR || busy !== 1'b1) begin
        n_err++;
        $display("FAIL start_accept: state=%0d busy=%b, expected HDR busy=1", state, busy);
      end
      @(negedge clk);
      n_vec++;
      if (uart_send !== 1'b1 || uart_data !== len[7:0]) begin
        n_err++;
        $display("FAIL first_send_latency: send=%b data=%02h, expected 1 %02h",
                 uart_send, uart_data, len[7:0]);
      end
    end
    if (busy_start) begin
      repeat (6) @(negedge clk);
      base_addr = 32'h0000_0900;
      length    = 32'd7;
      start     = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b0;
    end
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (state == S_IDLE && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL frame_timeout: state=%0d, expected IDLE within budget", state);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL frame_bytes: %0d bytes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
    n_vec++;
    if (done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL done_pulses: got %0d, expected 1", done_cnt - d0);
    end
    n_vec++;
    if (addr_q.size() != int'(len)) begin
      n_err++;
      $display("FAIL mem_reads: got %0d, expected %0d", addr_q.size(), len);
    end
    for (int i = 0; i < addr_q.size() && i < int'(len); i++) begin
      n_vec++;
      if (addr_q[i] !== b + 32'(i)) begin
        n_err++;
        $display("FAIL mem_addr[%0d]: got %08h, expected %08h", i, addr_q[i], b + 32'(i));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, mem_re, uart_send, uart_data, mem_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b re=%b send=%b data=%02h addr=%08h, expected all 0",
               busy, done, mem_re, uart_send, uart_data, mem_addr);
    end
    n_vec++;
    if (state !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d, expected IDLE", state);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    tb_mem[32'h100] = 8'hAA;
    tb_mem[32'h101] = 8'hBB;
    tb_mem[32'h102] = 8'hCC;
    run_frame(32'h0000_0100, 32'd3, 1'b1, 1'b0);
  endtask

  task automatic test_zero_len();
    run_frame(32'h0000_0400, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    run_frame(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
  endtask

  task automatic test_checksum();
    tb_mem[32'h300] = 8'h80;
    tb_mem[32'h301] = 8'h90;
    tb_mem[32'h302] = 8'hF0;
    run_frame(32'h0000_0300, 32'd3, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int  s0;
    bit  hit;
    push_frame(32'h0000_0100, 32'd3);
    s0 = sent_cnt;
    drive_start(32'h0000_0100, 32'd3);
    hit = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (sent_cnt == s0 + 2 && state == S_WAIT_LO) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL reach_wait_lo: state=%0d sent=%0d, expected WAIT_LO after 2 bytes",
               state, sent_cnt - s0);
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, done, mem_re, uart_send, uart_data, mem_addr} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: busy=%b done=%b re=%b send=%b data=%02h addr=%08h, expected all 0",
               busy, done, mem_re, uart_send, uart_data, mem_addr);
    end
    n_vec++;
    if (state !== S_IDLE) begin
      n_err++;
      $display("FAIL midreset_state: got %0d, expected IDLE", state);
    end
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    run_frame(32'h0000_0100, 32'd3, 1'b1, 1'b0);
  endtask

  task automatic test_enable_toggle();
    for (int i = 0; i < 4; i++) tb_mem[32'h200 + 32'(i)] = 8'($urandom_range(0, 255));
    en_toggle = 1'b1;
    run_frame(32'h0000_0200, 32'd4, 1'b0, 1'b1);
    en_toggle = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random_frames();
    logic [31:0] b;
    logic [31:0] len;
    for (int f = 0; f < 4; f++) begin
      b   = 32'($urandom());
      len = 32'($urandom_range(0, 5));
      run_frame(b, len, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    clk_enable = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    length     = '0;
    mem_data   = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_checksum();
    test_reset_mid();
    test_enable_toggle();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
